// File: rtl/multi_result_acc.sv
`default_nettype none
// ============================================================================
//  Module   : multi_result_acc
//  Brief    : Per-mode saturating accumulator for multiplier products. Sums
//             products separately for each mode select, tracks sample counts
//             and the window peak, and hands a frozen report downstream after
//             every WINDOW accepted samples.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_result_acc #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y,
  input  logic              in_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum0,
  output logic [ACC_W-1:0]  out_sum1,
  output logic [CNT_W-1:0]  out_cnt0,
  output logic [CNT_W-1:0]  out_cnt1,
  output logic              out_ovf0,
  output logic              out_ovf1,
  output logic [DATA_W-1:0] out_max
);

  localparam logic [0:0]       c_accum   = 1'b0;
  localparam logic [0:0]       c_report  = 1'b1;
  localparam logic [CNT_W-1:0] c_window  = CNT_W'(WINDOW);
  localparam logic [ACC_W-1:0] c_acc_max = {ACC_W{1'b1}};

  logic [0:0]       r_state;
  logic [0:0]       w_next_state;
  logic             r_in_ready;

  logic [ACC_W-1:0]  r_acc0;
  logic [ACC_W-1:0]  r_acc1;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;
  logic [CNT_W-1:0]  r_total;
  logic              r_ovf0;
  logic              r_ovf1;
  logic [DATA_W-1:0] r_max;

  logic              w_accept;
  logic              w_restart;
  logic [CNT_W-1:0]  w_total_inc;
  logic              w_window_done;
  logic [ACC_W:0]    w_add;
  logic              w_clamp;
  logic [ACC_W-1:0]  w_sat;

  // clr outranks any handshake, so a sample arriving with it is dropped
  assign w_accept      = in_valid & r_in_ready & ~clr & (r_state == c_accum);
  // both an explicit clear and a consumed report start a fresh window
  assign w_restart     = clr | ((r_state == c_report) & out_ready);
  assign w_total_inc   = r_total + CNT_W'(1);
  assign w_window_done = (w_total_inc == c_window);

  // one extra bit of headroom makes the carry-out the saturation flag
  assign w_add   = {1'b0, (in_s ? r_acc1 : r_acc0)}
                 + {{(ACC_W + 1 - DATA_W){1'b0}}, in_y};
  assign w_clamp = w_add[ACC_W];
  assign w_sat   = w_clamp ? c_acc_max : w_add[ACC_W-1:0];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_accum;
    else        r_state <= w_next_state;
  end

  // next-state: close the window on the WINDOW-th accept, reopen on consume
  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = c_accum;
    end else begin
      case (r_state)
        c_accum:  if (w_accept && w_window_done) w_next_state = c_report;
        c_report: if (out_ready)                 w_next_state = c_accum;
        default:  w_next_state = c_accum;
      endcase
    end
  end

  // output decode: a report is on offer for the whole REPORT state
  always_comb begin
    out_valid = (r_state == c_report);
  end

  // in_ready follows the upcoming state so it stays low out of reset until
  // the first edge and drops in the same cycle the report appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in_ready <= 1'b0;
    else        r_in_ready <= (w_next_state == c_accum);
  end

  // window datapath: per-mode saturating sums, counts, sticky overflow, peak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc0  <= '0;
      r_acc1  <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_total <= '0;
      r_ovf0  <= 1'b0;
      r_ovf1  <= 1'b0;
      r_max   <= '0;
    end else if (w_restart) begin
      r_acc0  <= '0;
      r_acc1  <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_total <= '0;
      r_ovf0  <= 1'b0;
      r_ovf1  <= 1'b0;
      r_max   <= '0;
    end else if (w_accept) begin
      if (in_s) begin
        r_acc1 <= w_sat;
        r_cnt1 <= r_cnt1 + CNT_W'(1);
        if (w_clamp) r_ovf1 <= 1'b1;
      end else begin
        r_acc0 <= w_sat;
        r_cnt0 <= r_cnt0 + CNT_W'(1);
        if (w_clamp) r_ovf0 <= 1'b1;
      end
      r_total <= w_total_inc;
      if (in_y > r_max) r_max <= in_y;
    end
  end

  assign in_ready = r_in_ready;
  assign out_sum0 = r_acc0;
  assign out_sum1 = r_acc1;
  assign out_cnt0 = r_cnt0;
  assign out_cnt1 = r_cnt1;
  assign out_ovf0 = r_ovf0;
  assign out_ovf1 = r_ovf1;
  assign out_max  = r_max;

endmodule
`default_nettype wire

// File: tb/tb_multi_result_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_result_acc
//  Brief    : Scoreboard bench for multi_result_acc. Stimulus pushes expected
//             reports computed from plain arithmetic over each window; a
//             monitor pops and compares on every report handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_result_acc;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 33;
  localparam int WINDOW = 4;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_y = '0;
  logic              in_s = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum0;
  logic [ACC_W-1:0]  out_sum1;
  logic [CNT_W-1:0]  out_cnt0;
  logic [CNT_W-1:0]  out_cnt1;
  logic              out_ovf0;
  logic              out_ovf1;
  logic [DATA_W-1:0] out_max;

  always #5 clk = ~clk;

  multi_result_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_s(in_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum0(out_sum0), .out_sum1(out_sum1),
    .out_cnt0(out_cnt0), .out_cnt1(out_cnt1),
    .out_ovf0(out_ovf0), .out_ovf1(out_ovf1), .out_max(out_max)
  );

  typedef struct {
    longint unsigned sum0;
    longint unsigned sum1;
    longint unsigned cnt0;
    longint unsigned cnt1;
    longint unsigned ovf0;
    longint unsigned ovf1;
    longint unsigned max;
  } rep_t;

  rep_t            exp_q[$];
  int              win_s[$];
  longint unsigned win_y[$];
  int              total = 0;
  int              bad = 0;
  int              accepted = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // reference: a report is the plain sum per mode, clamped to the ACC_W range
  function automatic void model_accept(int s, longint unsigned y);
    rep_t r;
    longint unsigned lim;
    lim = (64'd1 << ACC_W) - 64'd1;
    win_s.push_back(s);
    win_y.push_back(y);
    accepted++;
    if (win_s.size() == WINDOW) begin
      r = '{default: 0};
      for (int i = 0; i < WINDOW; i++) begin
        if (win_s[i] == 0) begin r.sum0 += win_y[i]; r.cnt0++; end
        else               begin r.sum1 += win_y[i]; r.cnt1++; end
        if (win_y[i] > r.max) r.max = win_y[i];
      end
      r.ovf0 = (r.sum0 > lim) ? 1 : 0;
      r.ovf1 = (r.sum1 > lim) ? 1 : 0;
      if (r.sum0 > lim) r.sum0 = lim;
      if (r.sum1 > lim) r.sum1 = lim;
      exp_q.push_back(r);
      win_s.delete();
      win_y.delete();
    end
  endfunction

  function automatic void model_clear();
    win_s.delete();
    win_y.delete();
    exp_q.delete();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, bit s, logic [31:0] y, bit ordy, bit c);
    in_valid = v; in_s = s; in_y = y; out_ready = ordy; clr = c;
    if (c)                  model_clear();
    else if (v && in_ready) model_accept(int'(s), longint'(y));
    step();
  endtask

  task automatic idle(bit ordy);
    drive(1'b0, 1'b0, 32'd0, ordy, 1'b0);
  endtask

  // monitor: every consumed report must match the oldest expected one
  always @(negedge clk) begin
    rep_t e;
    if (rst_n && out_valid && out_ready && !clr) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rep_unexpected: got out_valid=1 expected no report");
      end else begin
        e = exp_q.pop_front();
        chk("rep_sum0", 64'(out_sum0), e.sum0);
        chk("rep_sum1", 64'(out_sum1), e.sum1);
        chk("rep_cnt0", 64'(out_cnt0), e.cnt0);
        chk("rep_cnt1", 64'(out_cnt1), e.cnt1);
        chk("rep_ovf0", 64'(out_ovf0), e.ovf0);
        chk("rep_ovf1", 64'(out_ovf1), e.ovf1);
        chk("rep_max",  64'(out_max),  e.max);
        chk("rep_cnt_sum", 64'(out_cnt0) + 64'(out_cnt1), 64'(WINDOW));
      end
    end
  end

  initial begin
    int cyc;
    int target;

    // reset state
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready",  64'(in_ready),  0);
    chk("rst_sum0",      64'(out_sum0),  0);
    chk("rst_max",       64'(out_max),   0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rel_in_ready_before_edge", 64'(in_ready), 0);
    step();
    chk("rel_in_ready_first_edge", 64'(in_ready), 1);

    // basic window with both modes back-to-back
    drive(1, 1, 32'd3, 0, 0);
    drive(1, 0, 32'd1, 0, 0);
    drive(1, 1, 32'd3, 0, 0);
    drive(1, 0, 32'd1, 0, 0);
    chk("t1_out_valid", 64'(out_valid), 1);
    chk("t1_in_ready",  64'(in_ready),  0);
    idle(1);
    chk("t1_after_valid", 64'(out_valid), 0);
    chk("t1_after_ready", 64'(in_ready),  1);
    chk("t1_after_sum1",  64'(out_sum1),  0);
    chk("t1_after_max",   64'(out_max),   0);

    // saturation of mode 1, then hold the report while in_valid is driven
    repeat (4) drive(1, 1, 32'hFFFF_FFFF, 0, 0);
    chk("t2_pending", 64'(exp_q.size()), 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'($urandom_range(0, 1)), $urandom, 0, 0);
      chk("t3_hold_in_ready",  64'(in_ready),  0);
      chk("t3_hold_out_valid", 64'(out_valid), 1);
      chk("t3_hold_sum1",      64'(out_sum1),  exp_q[0].sum1);
      chk("t3_hold_cnt1",      64'(out_cnt1),  exp_q[0].cnt1);
      chk("t3_hold_ovf1",      64'(out_ovf1),  exp_q[0].ovf1);
    end
    idle(1);
    chk("t3_rel_valid", 64'(out_valid), 0);
    chk("t3_rel_ready", 64'(in_ready),  1);
    chk("t3_rel_sum1",  64'(out_sum1),  0);

    // clr mid-window with a coincident sample
    drive(1, 1, 32'd7, 0, 0);
    drive(1, 0, 32'd9, 0, 0);
    drive(1, 0, 32'd5, 0, 1);
    chk("t4_cnt0",     64'(out_cnt0),  0);
    chk("t4_cnt1",     64'(out_cnt1),  0);
    chk("t4_sum0",     64'(out_sum0),  0);
    chk("t4_in_ready", 64'(in_ready),  1);
    drive(1, 0, 32'd11, 0, 0);
    drive(1, 1, 32'd12, 0, 0);
    drive(1, 0, 32'd0,  0, 0);
    chk("t4_no_early_report", 64'(out_valid), 0);
    drive(1, 1, 32'd2,  0, 0);
    chk("t4_report", 64'(out_valid), 1);
    idle(1);

    // asynchronous reset while a report is pending
    repeat (4) drive(1, 0, 32'd100, 0, 0);
    chk("t5_report", 64'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("t5_async_valid", 64'(out_valid), 0);
    chk("t5_async_ready", 64'(in_ready),  0);
    chk("t5_async_sum0",  64'(out_sum0),  0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5_rel_ready_before", 64'(in_ready), 0);
    step();
    chk("t5_rel_ready_after", 64'(in_ready), 1);
    drive(1, 1, 32'd20, 0, 0);
    drive(1, 1, 32'd30, 0, 0);
    drive(1, 0, 32'd40, 0, 0);
    drive(1, 1, 32'd10, 0, 0);
    idle(1);

    // random throttling on both sides
    cyc = 0;
    target = accepted + 1000;
    while (accepted < target && cyc < 20000) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 1000),
            1'($urandom_range(0, 2) != 0), 1'b0);
      cyc++;
    end
    chk("rand_budget", 64'(cyc < 20000), 1);
    repeat (4) idle(1);
    chk("drain_queue_empty", 64'(exp_q.size()), 0);
    chk("drain_partial_cnt", 64'(out_cnt0) + 64'(out_cnt1), 64'(win_s.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
